// File: rtl/pout_byte_serializer.sv
// rtl/pout_byte_serializer.sv - word-to-byte pin serializer, LSB byte first
// A small word FIFO feeds a shift register; bytes flow back-to-back while words are queued.
module pout_byte_serializer #(
  parameter int WORD_W = 16,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int N     = WORD_W / BYTE_W;
  localparam int IDX_W = $clog2(N);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t state, state_next;

  logic [WORD_W:0]     fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [WORD_W:0]     fifo_head;
  logic                fifo_empty;
  logic                push;
  logic                load;

  logic [WORD_W-1:0]   shift;
  logic [IDX_W-1:0]    byte_idx;
  logic                last_q;
  logic                last_byte;
  logic                byte_xfer;

  assign fifo_empty = (count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign in_ready   = (count < FULL_CNT);
  assign push       = in_valid && in_ready;
  assign last_byte  = (byte_idx == LAST_IDX);
  assign byte_xfer  = out_valid && out_ready;
  assign busy       = !fifo_empty || (state == S_SEND);

  // Load (and pop) either from idle, or on the final byte so the next word follows without a gap.
  always_comb begin
    load = 1'b0;
    case (state)
      S_IDLE:  load = !fifo_empty;
      S_SEND:  load = byte_xfer && last_byte && !fifo_empty;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, load})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (byte_xfer && last_byte && fifo_empty) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state == S_SEND) begin
      out_valid = 1'b1;
      out_data  = shift[BYTE_W-1:0];
      out_last  = last_q && last_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift    <= '0;
      byte_idx <= '0;
      last_q   <= 1'b0;
    end else if (load) begin
      shift    <= fifo_head[WORD_W-1:0];
      last_q   <= fifo_head[WORD_W];
      byte_idx <= '0;
    end else if (byte_xfer) begin
      shift    <= shift >> BYTE_W;
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count <= 16'h0000;
    end else if (byte_xfer && out_last) begin
      frame_count <= frame_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_pout_byte_serializer.sv
// tb/tb_pout_byte_serializer.sv - scoreboard bench for pout_byte_serializer
// Expected bytes come from word arithmetic; a negedge monitor pops and compares every byte transfer.
module tb_pout_byte_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] frame_count;
  logic        busy;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_data;
  logic        w_in_last;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [7:0]  w_out_data;
  logic        w_out_last;
  logic [15:0] w_frame_count;
  logic        w_busy;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_fc = 16'h0000;
  int          ready_mode = 1;
  int          cyc = 0;
  bit          stream_mode = 1'b0;
  int          s_xfers, s_first, s_last, s_low_run, s_max_low;

  always #5 clock = ~clock;

  pout_byte_serializer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_count(frame_count), .busy(busy)
  );

  pout_byte_serializer #(.WORD_W(32), .BYTE_W(8), .DEPTH(2)) u_w32 (
    .clock(clock), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_last(w_in_last),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_last(w_out_last),
    .frame_count(w_frame_count), .busy(w_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Drive a word from posedge+1; expected bytes are queued at the negedge before the accepting edge.
  task automatic push_word(input logic [15:0] d, input logic l);
    int   t = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) begin
      chk("push_accept", 32'(in_ready), 32'd1);
    end else begin
      for (int i = 0; i < 2; i++) begin
        e.data = 8'((d >> (8 * i)) & 16'h00FF);
        e.last = l && (i == 1);
        q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((q.size() != 0 || busy) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk({name, "_drained"}, 32'(q.size() == 0 && !busy), 32'd1);
    sync();
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    exp_t       e;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(prev_data));
          chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", out_data);
          end else begin
            e = q.pop_front();
            chk("byte_data", 32'(out_data), 32'(e.data));
            chk("byte_last", 32'(out_last), 32'(e.last));
            if (e.last) exp_fc = exp_fc + 16'h0001;
          end
          if (stream_mode) begin
            if (s_xfers == 0) s_first = cyc;
            s_last = cyc;
            s_xfers++;
          end
        end
        if (stream_mode) begin
          if (!in_ready) begin
            s_low_run++;
            if (s_low_run > s_max_low) s_max_low = s_low_run;
          end else begin
            s_low_run = 0;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         t;
    int         got;
    logic [7:0] wb [4];
    logic       wl [4];
    logic [31:0] wword;

    reset = 1'b1;
    in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0;
    w_in_valid = 1'b0; w_in_data = 32'h0; w_in_last = 1'b0; w_out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sync();
    sync();
    reset = 1'b0;
    sync();

    // single word, latency and byte order
    push_word(16'h1234, 1'b0);
    @(negedge clock);
    chk("lat_not_yet_valid", 32'(out_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("single_v0", 32'(out_valid), 32'd1);
    chk("single_b0", 32'(out_data), 32'h34);
    @(negedge clock);
    chk("single_v1", 32'(out_valid), 32'd1);
    chk("single_b1", 32'(out_data), 32'h12);
    chk("single_last", 32'(out_last), 32'd0);
    @(negedge clock);
    chk("single_idle_valid", 32'(out_valid), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'd0);
    sync();

    // streaming: gapless output, short in_ready dips
    s_xfers = 0; s_first = 0; s_last = 0; s_low_run = 0; s_max_low = 0;
    stream_mode = 1'b1;
    for (int i = 0; i < 256; i++) push_word(16'(i), 1'b0);
    drain("stream");
    stream_mode = 1'b0;
    chk("stream_bytes", s_xfers, 512);
    chk("stream_span", s_last - s_first + 1, 512);
    chk("stream_in_ready_low", 32'(s_max_low <= 1), 32'd1);

    // backpressure: byte held, storage of DEPTH+1 words
    ready_mode = 0;
    sync();
    push_word(16'hBEEF, 1'b0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clock);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_ef", 32'(out_data), 32'hEF);
      @(negedge clock);
    end
    sync();
    push_word(16'($urandom), 1'b0);
    push_word(16'($urandom), 1'b0);
    @(negedge clock);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    sync();
    ready_mode = 1;
    drain("backpressure");

    // frames of 4 words
    t = int'(exp_fc);
    for (int f = 0; f < 3; f++)
      for (int w = 0; w < 4; w++) push_word(16'($urandom), w == 3);
    drain("frames");
    chk("frames_count", 32'(frame_count), 32'(16'(t + 3)));

    // frame counter wrap
    force dut.frame_count = 16'hFFFF;
    exp_fc = 16'hFFFF;
    #1;
    release dut.frame_count;
    push_word(16'h00C3, 1'b1);
    drain("wrap");
    chk("frame_wrap", 32'(frame_count), 32'd0);

    // randomized traffic with random backpressure and input gaps
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) sync();
      push_word(16'($urandom), $urandom_range(0, 3) == 0);
    end
    ready_mode = 1;
    drain("random");

    // reset in the middle of a word
    ready_mode = 0;
    sync();
    push_word(16'hA55A, 1'b0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("mid_first_byte", 32'(out_data), 32'h5A);
    @(posedge clock);
    #1;
    ready_mode = 1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
    q.delete();
    exp_fc = 16'h0000;
    sync();
    reset = 1'b0;
    push_word(16'h1357, 1'b0);
    drain("after_reset");

    // 32-bit word variant
    chk("w32_in_ready", 32'(w_in_ready), 32'd1);
    wword = 32'h11223344;
    w_in_valid = 1'b1; w_in_data = wword; w_in_last = 1'b1;
    sync();
    w_in_valid = 1'b0;
    got = 0;
    t = 0;
    while (got < 4 && t < 20) begin
      @(negedge clock);
      if (w_out_valid) begin
        wb[got] = w_out_data;
        wl[got] = w_out_last;
        got++;
      end
      t++;
    end
    chk("w32_byte_count", got, 4);
    for (int i = 0; i < 4; i++) begin
      chk("w32_byte", 32'(wb[i]), (wword >> (8 * i)) & 32'hFF);
      chk("w32_last", 32'(wl[i]), 32'(i == 3));
    end
    @(negedge clock);
    chk("w32_frame_count", 32'(w_frame_count), 32'd1);
    chk("w32_busy", 32'(w_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
